// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and default timing.
// Used by the receiver, the transmitter and the benches.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_DELAY_FRAMES = 234;   // 27 MHz / 115200 baud
    localparam int CLK_PERIOD_NS     = 37;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector. All flops reset to the idle-high level so reset release never
// produces a spurious start edge.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and previous-sample register for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= uart_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver, 8 data bits LSB first, one stop bit, sampling at mid-bit.
// Optional even parity bit after the data when UART_RX_PARITY_EN is defined;
// otherwise the frame is 8N1 and parity_err is tied low.
// Received bytes sit in a valid/ready holding register; framing, parity and
// overrun errors are single-cycle pulses.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line idle, waiting for a synchronized falling edge
//   ST_START  | counting to mid start bit to reject glitches
//   ST_DATA   | shifting in 8 data bits, one per bit time
//   ST_PARITY | sampling the parity bit (parity build only)
//   ST_STOP   | sampling the stop bit and delivering / flagging the byte
//   ST_BREAK  | line held low after a framing error, wait for it to go high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = UART_DELAY_FRAMES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun
);

    localparam int HALF_DELAY = DELAY_FRAMES / 2;
    localparam int CNT_W      = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    logic                      w_fall;

    uart_state_t               r_state;
    uart_state_t               w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic                      w_half_tick;
    logic                      w_full_tick;
    logic                      w_cnt_run;
    logic                      w_shift_en;
    logic                      w_deliver;
    logic                      w_frame_fail;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad;
    logic                      r_parity_err;
    logic                      w_par_check;
    logic                      w_par_fail;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx_s    (w_rx_s),
        .fall    (w_fall)
    );

    assign w_half_tick = (r_cnt == CNT_HALF);
    assign w_full_tick = (r_cnt == CNT_FULL);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state strobes; w_cnt_run=0 parks the counter at 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_run    = 1'b0;
        w_shift_en   = 1'b0;
        w_deliver    = 1'b0;
        w_frame_fail = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_check  = 1'b0;
        w_par_fail   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Start bit still high at its middle means a glitch, not a frame.
                if (w_half_tick) begin
                    w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
            ST_DATA: begin
                w_cnt_run = 1'b1;
                if (w_full_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                w_cnt_run = 1'b1;
                if (w_full_tick) begin
                    w_par_check = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                w_cnt_run = 1'b1;
                // Leaving at mid-stop gives half a bit of slack before a back-to-back start edge.
                if (w_full_tick) begin
                    if (!w_rx_s) begin
                        w_frame_fail = 1'b1;
                        w_state_nxt  = ST_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_par_fail  = 1'b1;
                        w_state_nxt = ST_IDLE;
`endif
                    end else begin
                        w_deliver   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit-time counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (!w_cnt_run || w_full_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state != ST_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch flag, cleared between frames and reported at the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_fail;
            if (r_state == ST_IDLE) begin
                r_par_bad <= 1'b0;
            end else if (w_par_check) begin
                r_par_bad <= (w_rx_s != even_parity(r_shift));
            end
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // Holding register: load when empty or being drained this cycle, else drop and flag overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_fail;
            r_overrun   <= 1'b0;
            if (w_deliver) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
